// File: rtl/timing_sequencer.sv
// Instruction timing sequencer: a 4-bit sequence counter with one-hot
// timing signals T0..T15, interrupt-cycle selection and a wrap error flag.
//
// Ports:
//   clk      - system clock, all state changes on the rising edge
//   rst_n    - asynchronous active-low reset
//   start    - pulse that begins or restarts sequencing
//   halt     - HLT decoded by the datapath; stops sequencing
//   sc_clr   - end of instruction; sequence counter returns to 0
//   stall    - memory not ready; sequence counter holds
//   ien      - interrupt enable flip-flop
//   irq      - interrupt request (FGI|FGO)
//   sc       - sequence counter value
//   t        - one-hot timing signals, 1<<sc while running, else 0
//   running  - high while sequencing
//   r_cycle  - current instruction slot is an interrupt cycle
//   err      - sticky: the counter wrapped without sc_clr
module timing_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        sc_clr,
    input  logic        stall,
    input  logic        ien,
    input  logic        irq,
    output logic [3:0]  sc,
    output logic [15:0] t,
    output logic        running,
    output logic        r_cycle,
    output logic        err
);

    localparam int unsigned SC_W = 4;
    localparam int unsigned T_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;

    // Sequencer state and all outputs; t is kept one-hot in step with sc by
    // rotating it on every increment, so it never lags the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sc      <= '0;
            t       <= '0;
            running <= 1'b0;
            r_cycle <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    // Only start is honoured outside RUN.
                    if (start) begin
                        state   <= RUN;
                        sc      <= '0;
                        t       <= T_W'(1);
                        running <= 1'b1;
                        r_cycle <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                RUN: begin
                    if (start) begin
                        sc      <= '0;
                        t       <= T_W'(1);
                        r_cycle <= 1'b0;
                        err     <= 1'b0;
                    end else if (halt) begin
                        // r_cycle deliberately left untouched.
                        state   <= HALTED;
                        sc      <= '0;
                        t       <= '0;
                        running <= 1'b0;
                    end else if (sc_clr) begin
                        sc      <= '0;
                        t       <= T_W'(1);
                        r_cycle <= ien & irq;
                    end else if (!stall) begin
                        sc <= sc + SC_W'(1);
                        t  <= {t[T_W-2:0], t[T_W-1]};
                        if (sc == SC_W'(15)) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    sc      <= '0;
                    t       <= '0;
                    running <= 1'b0;
                    r_cycle <= 1'b0;
                    err     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timing_sequencer.sv
// Self-checking bench for timing_sequencer: directed vector table, hand
// sequences for wrap and asynchronous reset, and random stimulus checked
// against a behavioural model of the sequencing rules.
module tb_timing_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic        sc_clr;
    logic        stall;
    logic        ien;
    logic        irq;
    logic [3:0]  sc;
    logic [15:0] t;
    logic        running;
    logic        r_cycle;
    logic        err;

    int checks = 0;
    int errors = 0;

    timing_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .halt    (halt),
        .sc_clr  (sc_clr),
        .stall   (stall),
        .ien     (ien),
        .irq     (irq),
        .sc      (sc),
        .t       (t),
        .running (running),
        .r_cycle (r_cycle),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 = idle, 1 = sequencing, 2 = halted.
    int m_mode;
    int m_cnt;
    bit m_r;
    bit m_e;

    function automatic void model_reset();
        m_mode = 0;
        m_cnt  = 0;
        m_r    = 0;
        m_e    = 0;
    endfunction

    function automatic void model_clock(input bit s, input bit h, input bit c,
                                        input bit st, input bit ie, input bit ir);
        if (m_mode != 1) begin
            if (s) begin
                m_mode = 1; m_cnt = 0; m_r = 0; m_e = 0;
            end
        end else if (s) begin
            m_cnt = 0; m_r = 0; m_e = 0;
        end else if (h) begin
            m_mode = 2; m_cnt = 0;
        end else if (c) begin
            m_cnt = 0; m_r = ie & ir;
        end else if (!st) begin
            if (m_cnt == 15) m_e = 1;
            m_cnt = (m_cnt + 1) % 16;
        end
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_sc, input logic [15:0] e_t,
                           input logic e_run, input logic e_r, input logic e_err);
        chk({tag, ".sc"},      16'(sc),      16'(e_sc));
        chk({tag, ".t"},       t,            e_t);
        chk({tag, ".running"}, 16'(running), 16'(e_run));
        chk({tag, ".r_cycle"}, 16'(r_cycle), 16'(e_r));
        chk({tag, ".err"},     16'(err),     16'(e_err));
    endtask

    task automatic chk_model(input string tag);
        logic [15:0] e_t;
        e_t = (m_mode == 1) ? 16'(1 << m_cnt) : 16'h0000;
        chk_all(tag, 4'(m_cnt), e_t, logic'(m_mode == 1), m_r, m_e);
    endtask

    // Drive one cycle of inputs after the falling edge, clock it, sample 1 ns later.
    task automatic step(input bit s, input bit h, input bit c,
                        input bit st, input bit ie, input bit ir);
        @(negedge clk);
        start = s; halt = h; sc_clr = c; stall = st; ien = ie; irq = ir;
        @(posedge clk);
        model_clock(s, h, c, st, ie, ir);
        #1;
    endtask

    typedef struct {
        bit          s, h, c, st, ie, ir;
        logic [3:0]  e_sc;
        logic [15:0] e_t;
        logic        e_run, e_r, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input bit s, input bit h, input bit c, input bit st,
                               input bit ie, input bit ir, input logic [3:0] e_sc,
                               input logic [15:0] e_t, input logic e_run,
                               input logic e_r, input logic e_err);
        vec_t x;
        x.s = s; x.h = h; x.c = c; x.st = st; x.ie = ie; x.ir = ir;
        x.e_sc = e_sc; x.e_t = e_t; x.e_run = e_run; x.e_r = e_r; x.e_err = e_err;
        return x;
    endfunction

    initial begin
        // start halt clr stall ien irq | sc t run r err
        vecs.push_back(v(1,0,0,0,0,0, 0, 16'h0001, 1, 0, 0)); // fetch
        vecs.push_back(v(0,0,0,0,0,0, 1, 16'h0002, 1, 0, 0));
        vecs.push_back(v(0,0,0,0,0,0, 2, 16'h0004, 1, 0, 0));
        vecs.push_back(v(0,0,0,0,0,0, 3, 16'h0008, 1, 0, 0));
        vecs.push_back(v(0,0,1,0,0,0, 0, 16'h0001, 1, 0, 0));
        vecs.push_back(v(0,0,0,0,0,0, 1, 16'h0002, 1, 0, 0));
        vecs.push_back(v(0,0,0,0,0,0, 2, 16'h0004, 1, 0, 0));
        vecs.push_back(v(0,0,0,1,0,0, 2, 16'h0004, 1, 0, 0)); // stall x3
        vecs.push_back(v(0,0,0,1,1,1, 2, 16'h0004, 1, 0, 0));
        vecs.push_back(v(0,0,0,1,0,0, 2, 16'h0004, 1, 0, 0));
        vecs.push_back(v(0,0,0,0,0,0, 3, 16'h0008, 1, 0, 0));
        vecs.push_back(v(0,0,0,0,0,0, 4, 16'h0010, 1, 0, 0));
        vecs.push_back(v(0,0,0,0,0,0, 5, 16'h0020, 1, 0, 0));
        vecs.push_back(v(0,0,1,1,1,1, 0, 16'h0001, 1, 1, 0)); // clr beats stall, intr
        vecs.push_back(v(0,0,0,0,1,0, 1, 16'h0002, 1, 1, 0)); // irq outside clr
        vecs.push_back(v(0,0,0,0,0,1, 2, 16'h0004, 1, 1, 0));
        vecs.push_back(v(0,0,0,0,0,0, 3, 16'h0008, 1, 1, 0));
        vecs.push_back(v(0,0,0,0,0,0, 4, 16'h0010, 1, 1, 0));
        vecs.push_back(v(0,0,0,0,0,0, 5, 16'h0020, 1, 1, 0));
        vecs.push_back(v(0,0,1,0,1,0, 0, 16'h0001, 1, 0, 0)); // irq=0
        vecs.push_back(v(0,0,0,0,1,1, 1, 16'h0002, 1, 0, 0));
        vecs.push_back(v(0,0,0,0,1,1, 2, 16'h0004, 1, 0, 0));
        vecs.push_back(v(0,0,0,0,1,1, 3, 16'h0008, 1, 0, 0));
        vecs.push_back(v(0,0,0,0,1,1, 4, 16'h0010, 1, 0, 0));
        vecs.push_back(v(0,1,1,0,1,1, 0, 16'h0000, 0, 0, 0)); // halt beats clr
        vecs.push_back(v(0,0,0,1,1,1, 0, 16'h0000, 0, 0, 0)); // halted ignores
        vecs.push_back(v(0,0,1,0,1,1, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(v(0,1,0,0,0,0, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(v(1,0,0,0,0,0, 0, 16'h0001, 1, 0, 0)); // restart from halted
        vecs.push_back(v(0,0,0,0,0,0, 1, 16'h0002, 1, 0, 0));
        vecs.push_back(v(1,0,0,0,0,0, 0, 16'h0001, 1, 0, 0)); // restart in run

        start = 0; halt = 0; sc_clr = 0; stall = 0; ien = 0; irq = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after release, nothing but start has effect.
        step(0,1,1,1,1,1);
        chk_all("idle_ignore", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].h, vecs[i].c, vecs[i].st, vecs[i].ie, vecs[i].ir);
            chk_all($sformatf("vec%0d", i), vecs[i].e_sc, vecs[i].e_t,
                    vecs[i].e_run, vecs[i].e_r, vecs[i].e_err);
        end

        // Wrap: 15 increments to sc=15, one more wraps and sets err.
        repeat (15) step(0,0,0,0,0,0);
        chk_all("wrap_pre", 4'd15, 16'h8000, 1'b1, 1'b0, 1'b0);
        step(0,0,0,0,0,0);
        chk_all("wrap", 4'd0, 16'h0001, 1'b1, 1'b0, 1'b1);
        step(0,0,1,0,0,0);
        chk_all("wrap_clr", 4'd0, 16'h0001, 1'b1, 1'b0, 1'b1);
        step(0,0,0,0,0,0);
        chk_all("wrap_run", 4'd1, 16'h0002, 1'b1, 1'b0, 1'b1);
        step(1,0,0,0,0,0);
        chk_all("wrap_start", 4'd0, 16'h0001, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges at sc=7 (r_cycle set first).
        step(0,0,1,0,1,1);
        repeat (7) step(0,0,0,0,0,0);
        chk_all("pre_areset", 4'd7, 16'h0080, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("areset", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            step(0,0,0,0,1,1);
            chk_all("post_areset", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        end
        step(1,0,0,0,0,0);
        chk_all("post_start", 4'd0, 16'h0001, 1'b1, 1'b0, 1'b0);

        // Random stimulus against the model.
        for (int n = 0; n < 2000; n++) begin
            bit s, h, c, st, ie, ir;
            s  = ($urandom_range(99) < 3);
            h  = ($urandom_range(99) < 3);
            c  = ($urandom_range(99) < 12);
            st = ($urandom_range(99) < 25);
            ie = 1'($urandom_range(1));
            ir = 1'($urandom_range(1));
            step(s, h, c, st, ie, ir);
            chk_model($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
